// File: rtl/cpu_dp_pkg.sv
// rtl/cpu_dp_pkg.sv - op codes, operand-B select encodings and multiplier FSM states
package cpu_dp_pkg;

    localparam logic [3:0] OP_LD    = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_ADC   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_SBB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_MFHI  = 4'hC;
    localparam logic [3:0] OP_CLRF  = 4'hD;
    localparam logic [3:0] OP_NOP_E = 4'hE;
    localparam logic [3:0] OP_NOP_F = 4'hF;

    // Any select with bit 1 set reads the data memory.
    localparam logic [1:0] BSEL_IMM = 2'b00;
    localparam logic [1:0] BSEL_REG = 2'b01;
    localparam logic [1:0] BSEL_MEM = 2'b10;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_RUN  = 1'b1
    } mul_state_t;

endpackage

// File: rtl/cpu_mul_seq.sv
// rtl/cpu_mul_seq.sv - iterative shift-add unsigned multiplier, one bit per clock
module cpu_mul_seq
    import cpu_dp_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi
);
    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_t         r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_p_nxt;
    logic               w_last;

    // Product register holds {partial HI, remaining multiplier bits}; shift right each step.
    assign w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_a : {WIDTH{1'b0}})};
    assign w_p_nxt = {w_sum, r_p[WIDTH-1:1]};
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    assign o_busy = (r_state == MUL_RUN);
    assign o_done = o_busy && w_last;
    assign o_lo   = w_p_nxt[WIDTH-1:0];
    assign o_hi   = w_p_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MUL_IDLE: if (i_start) w_state_nxt = MUL_RUN;
            MUL_RUN:  if (w_last)  w_state_nxt = MUL_IDLE;
            default:               w_state_nxt = MUL_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_p   <= '0;
            r_cnt <= '0;
        end else if (r_state == MUL_IDLE) begin
            if (i_start) begin
                r_a   <= i_a;
                r_p   <= {{WIDTH{1'b0}}, i_b};
                r_cnt <= '0;
            end
        end else begin
            r_p   <= w_p_nxt;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_data_mc.sv
// rtl/cpu_data_mc.sv - accumulator datapath: register file, data memory, 16-op ALU, flags, multiplier
module cpu_data_mc
    import cpu_dp_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NREGS      = 8,
    parameter int DMEM_DEPTH = 256
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [3:0]               i_op,
    input  logic                     i_en_acc,
    input  logic [1:0]               i_in_b_sel,
    input  logic [WIDTH-1:0]         i_imm,
    input  logic [$clog2(NREGS)-1:0] i_reg_sel,
    input  logic                     i_en_reg_f,
    input  logic [WIDTH-1:0]         i_d_mem_addr,
    input  logic                     i_d_mem_addr_mode,
    input  logic                     i_en_d_mem,
    output logic [WIDTH-1:0]         o_acc_out,
    output logic [WIDTH-1:0]         o_port_out,
    output logic                     o_z,
    output logic                     o_c,
    output logic                     o_b,
    output logic                     o_n,
    output logic                     o_busy
);
    localparam int AW = $clog2(DMEM_DEPTH);

    logic [WIDTH-1:0] r_acc, r_hi;
    logic             r_z, r_c, r_b, r_n;
    logic [WIDTH-1:0] r_rf   [NREGS];
    logic [WIDTH-1:0] r_dmem [DMEM_DEPTH];

    logic [WIDTH-1:0] w_rf_rd, w_bop, w_acc_d, w_hi_d, w_mul_lo, w_mul_hi;
    logic [AW-1:0]    w_mem_addr;
    logic [WIDTH:0]   w_sum;
    logic             w_acc_we, w_c_d, w_b_d, w_cin;
    logic             w_busy, w_mul_done, w_mul_start;

    assign w_rf_rd    = r_rf[i_reg_sel];
    assign w_mem_addr = i_d_mem_addr_mode ? w_rf_rd[AW-1:0] : i_d_mem_addr[AW-1:0];

    always_comb begin
        case (i_in_b_sel)
            BSEL_IMM: w_bop = i_imm;
            BSEL_REG: w_bop = w_rf_rd;
            default:  w_bop = r_dmem[w_mem_addr];
        endcase
    end

    assign w_mul_start = i_en_acc && !w_busy && (i_op == OP_MUL);
    assign w_cin       = (i_op == OP_ADC) ? r_c : ((i_op == OP_SBB) ? r_b : 1'b0);

    cpu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (w_mul_start),
        .i_a     (r_acc),
        .i_b     (w_bop),
        .o_busy  (w_busy),
        .o_done  (w_mul_done),
        .o_lo    (w_mul_lo),
        .o_hi    (w_mul_hi)
    );

    always_comb begin
        w_acc_d  = r_acc;
        w_acc_we = 1'b0;
        w_c_d    = r_c;
        w_b_d    = r_b;
        w_hi_d   = r_hi;
        w_sum    = '0;
        if (w_mul_done) begin
            w_acc_we = 1'b1;
            w_acc_d  = w_mul_lo;
            w_hi_d   = w_mul_hi;
            w_c_d    = |w_mul_hi;
        end else if (i_en_acc && !w_busy) begin
            w_acc_we = 1'b1;
            case (i_op)
                OP_LD:  w_acc_d = w_bop;
                OP_ADD, OP_ADC: begin
                    w_sum   = {1'b0, r_acc} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_cin};
                    w_acc_d = w_sum[WIDTH-1:0];
                    w_c_d   = w_sum[WIDTH];
                end
                OP_SUB, OP_SBB: begin
                    w_sum   = {1'b0, r_acc} - {1'b0, w_bop} - {{WIDTH{1'b0}}, w_cin};
                    w_acc_d = w_sum[WIDTH-1:0];
                    w_b_d   = w_sum[WIDTH];
                end
                OP_AND: w_acc_d = r_acc & w_bop;
                OP_OR:  w_acc_d = r_acc | w_bop;
                OP_XOR: w_acc_d = r_acc ^ w_bop;
                OP_NOT: w_acc_d = ~r_acc;
                OP_SHL: begin
                    w_acc_d = {r_acc[WIDTH-2:0], 1'b0};
                    w_c_d   = r_acc[WIDTH-1];
                end
                OP_SHR: begin
                    w_acc_d = {1'b0, r_acc[WIDTH-1:1]};
                    w_c_d   = r_acc[0];
                end
                OP_MFHI: w_acc_d = r_hi;
                OP_CLRF: begin
                    w_acc_we = 1'b0;
                    w_c_d    = 1'b0;
                    w_b_d    = 1'b0;
                end
                OP_MUL, OP_NOP_E, OP_NOP_F: w_acc_we = 1'b0;
                default:                    w_acc_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_hi  <= '0;
            r_z   <= 1'b0;
            r_c   <= 1'b0;
            r_b   <= 1'b0;
            r_n   <= 1'b0;
        end else begin
            if (w_acc_we) begin
                r_acc <= w_acc_d;
                r_z   <= (w_acc_d == '0);
                r_n   <= w_acc_d[WIDTH-1];
            end
            r_c  <= w_c_d;
            r_b  <= w_b_d;
            r_hi <= w_hi_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
        end else if (i_en_reg_f && !w_busy) begin
            r_rf[i_reg_sel] <= r_acc;
        end
    end

    // Memory contents survive reset, so no reset branch here.
    always_ff @(posedge i_clk) begin
        if (i_en_d_mem && !w_busy) r_dmem[w_mem_addr] <= r_acc;
    end

    assign o_acc_out  = r_acc;
    assign o_port_out = r_rf[NREGS-1];
    assign o_z        = r_z;
    assign o_c        = r_c;
    assign o_b        = r_b;
    assign o_n        = r_n;
    assign o_busy     = w_busy;

endmodule

// File: doc/cpu_data_mc.md
# cpu_data_mc

Parametrised multi-cycle successor to the CPU accumulator datapath: register file, data memory, ALU, accumulator and flag register, extended with N/C/Z/B flags, a 16-op ALU and an iterative shift-add multiplier. It sits between the control unit (which drives the op and enables) and the port/memory side. Multi-cycle multiply raises `BUSY`, and the control unit stalls until it drops.

## Interface
- `WIDTH`, 8: data width. Must be at least 4.
- `NREGS`, 8: register-file entries. Register `NREGS-1` drives `PORT_OUT`.
- `DMEM_DEPTH`, 256: data-memory words, a power of 2, at most 2^WIDTH.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `OP` in 4: ALU operation, encoded per `cpu_dp_pkg`.
- `EN_ACC` in 1: execute `OP` into ACC this cycle.
- `IN_B_SEL` in 2: operand B source. 00 IMM, 01 register file, 1x data memory.
- `IMM` in WIDTH: immediate operand.
- `REG_SEL` in $clog2(NREGS): register-file read/write index.
- `EN_REG_F` in 1: write ACC into reg[`REG_SEL`].
- `D_MEM_ADDR` in WIDTH: direct data-memory address.
- `D_MEM_ADDR_MODE` in 1: address source. 0 uses `D_MEM_ADDR`; 1 uses reg[`REG_SEL`].
- `EN_D_MEM` in 1: write ACC into the data memory.
- `ACC_OUT` out WIDTH: accumulator value.
- `PORT_OUT` out WIDTH: reg[NREGS-1].
- `Z`, `C`, `B`, `N` out 1 each: flags.
- `BUSY` out 1: multiplier in progress.

## Operation
- Op codes:
  - 0 LD: ACC=Bop.
  - 1 ADD, 2 ADC (adds +C).
  - 3 SUB, 4 SBB (subtracts −B).
  - 5 AND, 6 OR, 7 XOR.
  - 8 NOT: ~ACC.
  - 9 SHL, A SHR: logical, by 1.
  - B MUL.
  - C MFHI: ACC=HI.
  - D CLRF: clear C and B, ACC unchanged.
  - E, F NOP.
- Flag update rules:
  - Z and N are recomputed from the new ACC on every ACC write.
  - C is updated by ADD/ADC (carry-out), SHL (old msb), SHR (old lsb) and MUL (HI≠0).
  - B is updated by SUB/SBB (borrow-out).
  - Flags not listed for an op hold their value. NOP writes nothing.
- Arithmetic is modulo 2^WIDTH. The carry/borrow is the (WIDTH+1)-th bit.
- Memory address is taken from the low $clog2(DMEM_DEPTH) bits. Register-file and data-memory reads are combinational.
- MUL: unsigned ACC×Bop. The low WIDTH bits go to ACC, the high WIDTH bits go to the HI register.
- While `BUSY`=1, `EN_ACC`, `EN_REG_F` and `EN_D_MEM` are ignored: no state is written except by the multiplier.
- Sub-FSM states:
  - IDLE goes to RUN on EN_ACC with OP=MUL.
  - RUN counts WIDTH iterations, then returns to IDLE.
- Reset values: ACC=0, HI=0, all flags 0, all registers 0, `BUSY`=0, FSM in IDLE. Data-memory contents are not reset.
- `RST_N` asserted mid-MUL aborts the multiply and applies the reset values immediately.

## Timing
- Single-cycle ops: ACC and flags update at the rising edge where EN_ACC=1.
- Register-file and data-memory writes capture the pre-edge ACC. The same edge may also update ACC.
- When EN_REG_F and EN_ACC are both high, the register receives the old ACC.
- A write and a read of the same register/address in one cycle return the old value that cycle and the new value the next cycle.
- MUL accepted at edge 0:
  - Operands are latched at edge 0. `BUSY` rises after edge 0.
  - One iteration runs per edge 1..WIDTH.
  - ACC, HI, Z, N and C are written at edge WIDTH. `BUSY` falls after edge WIDTH.
  - The first new op is sampled at edge WIDTH+1.
- `BUSY` is a registered output with no combinational path from the inputs.

## Structure
- Package `cpu_dp_pkg` holds:
  - the op-code localparams;
  - the IN_B_SEL encodings;
  - the multiplier FSM state enum.
- Sub-module `cpu_mul_seq` contains the shift-add multiplier:
  - ports: CLK, RST_N, START, A, B, BUSY, DONE, LO, HI;
  - holds its own iteration counter of $clog2(WIDTH)+1 bits.
- The register file, data memory, ALU and flags stay in `cpu_data_mc`.

## Test plan
- Reset, then CLRF/NOP: all outputs are 0. LD IMM=0x80 → ACC=0x80, N=1, Z=0.
- LD 0xFF, ADD IMM 0x01 → ACC=0x00, C=1, Z=1. Then ADC IMM 0x00 → ACC=0x01, C=0.
- LD 0x05, SUB IMM 0x07 → ACC=0xFE, B=1, N=1. Then SBB IMM 0x00 → ACC=0xFD.
- LD 0x0F, MUL IMM 0x11 (WIDTH=8):
  - `BUSY` is high for 8 cycles.
  - ACC=0xFF, HI=0x00, C=0.
  - EN_REG_F pulsed during BUSY leaves the register unchanged.
- Write ACC=0x20 to R3, then store to memory with D_MEM_ADDR_MODE=1, REG_SEL=3 → LD with IN_B_SEL=1x and D_MEM_ADDR=0x20 returns the stored value.
- Start MUL 0xFF×0xFF, drop RST_N at cycle 4 → ACC=0, HI=0, BUSY=0 immediately. After release, MUL completes with ACC=0x01, HI=0xFE, C=1.
